// File: rtl/ps2_pkg.sv
// Shared types and timing helpers for the PS/2 host-side command sequencer.
// Pure declarations: no latency, no flow control.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SEND,
    ST_ACK,
    ST_RESP
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_NO_ACK   = 2'd0,
    ERR_RESP_TO  = 2'd1,
    ERR_RESP_BAD = 2'd2,
    ERR_BIT_TO   = 2'd3
  } ps2_err_e;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // Divide first so millisecond spans at tens of MHz stay inside 32 bits.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 32'd1_000) * ms;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus a falling-edge strobe.
// Latency: pad change visible on sync_o/fall_o two cycles later; no backpressure.
module ps2_line_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle (pulled-up) level so no spurious edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer: inhibit, host-to-device frame, line-ACK, response check with resend retry.
// cmd_ready low whenever busy or the device owns the clock; optional bit watchdog under PS2_BIT_TIMEOUT_EN.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 16_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned RESP_MS    = 15,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned BIT_TO_US  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       kbd_clk_in,
  input  logic       kbd_data_in,
  output logic       kbd_clk_oe,
  output logic       kbd_data_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_enable,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] resp_data
);

  localparam int unsigned INH_CYC  = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned RESP_CYC = ms_to_cycles(CLK_HZ, RESP_MS);
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int RESP_W  = $clog2(RESP_CYC + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  logic clk_sync, clk_fall, data_sync, unused_data_fall;

  ps2_line_sync #(.RST_VAL(1'b1)) u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (kbd_clk_in),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync #(.RST_VAL(1'b1)) u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (kbd_data_in),
    .sync_o (data_sync),
    .fall_o (unused_data_fall)
  );

  ps2_state_e          state_q, state_d;
  logic [7:0]          byte_q, byte_d;
  logic                par_q, par_d;
  logic [3:0]          bit_q, bit_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [INH_W-1:0]    inh_q, inh_d;
  logic [RESP_W-1:0]   tmr_q, tmr_d;
  logic                clk_oe_q, clk_oe_d;
  logic                data_oe_q, data_oe_d;
  logic [7:0]          resp_q, resp_d;
  logic                accept, tx_bit, bit_to;
  ps2_err_e            code;

  assign tx_bit = bit_q[3] ? par_q : byte_q[bit_q[2:0]];

`ifdef PS2_BIT_TIMEOUT_EN
  localparam int unsigned BIT_CYC = us_to_cycles(CLK_HZ, BIT_TO_US);
  localparam int BIT_W = $clog2(BIT_CYC + 1);

  logic [BIT_W-1:0] wd_q, wd_d;

  // Restarts at every clock fall; held clear during INHIBIT so the first gap is measured from release.
  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_INHIBIT || clk_fall) begin
      wd_d = '0;
    end else if (wd_q != BIT_W'(BIT_CYC)) begin
      wd_d = wd_q + BIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  assign bit_to = (wd_q == BIT_W'(BIT_CYC));
`else
  logic unused_bit_to_us;
  assign unused_bit_to_us = ^BIT_TO_US;
  assign bit_to = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    par_d     = par_q;
    bit_d     = bit_q;
    retry_d   = retry_q;
    inh_d     = inh_q;
    tmr_d     = tmr_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    resp_d    = resp_q;
    accept    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    code      = ERR_NO_ACK;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          byte_d    = cmd_data;
          par_d     = ~^cmd_data;
          retry_d   = '0;
          inh_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end

      // Clock held low INH_CYC cycles, start bit asserted, clock released one cycle later.
      ST_INHIBIT: begin
        if (inh_q == INH_W'(INH_CYC)) begin
          clk_oe_d = 1'b0;
          bit_d    = '0;
          state_d  = ST_SEND;
        end else begin
          inh_d = inh_q + INH_W'(1);
          if (inh_q == INH_W'(INH_CYC - 1)) data_oe_d = 1'b1;
        end
      end

      ST_SEND: begin
        if (clk_fall) begin
          if (bit_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            data_oe_d = ~tx_bit;
            bit_d     = bit_q + 4'd1;
          end
        end else if (bit_to) begin
          err  = 1'b1;
          code = ERR_BIT_TO;
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          if (!data_sync) begin
            tmr_d   = '0;
            state_d = ST_RESP;
          end else begin
            err  = 1'b1;
            code = ERR_NO_ACK;
          end
        end else if (bit_to) begin
          err  = 1'b1;
          code = ERR_BIT_TO;
        end
      end

      ST_RESP: begin
        if (rx_valid) begin
          resp_d = rx_data;
          if (rx_data == PS2_ACK) begin
            done = 1'b1;
          end else if (rx_data == PS2_RESEND && retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d   = retry_q + RETRY_W'(1);
            inh_d     = '0;
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            state_d   = ST_INHIBIT;
          end else begin
            err  = 1'b1;
            code = ERR_RESP_BAD;
          end
        end else if (tmr_q == RESP_W'(RESP_CYC - 1)) begin
          err  = 1'b1;
          code = ERR_RESP_TO;
        end else begin
          tmr_d = tmr_q + RESP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (done || err) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      par_q     <= 1'b0;
      bit_q     <= '0;
      retry_q   <= '0;
      inh_q     <= '0;
      tmr_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      retry_q   <= retry_d;
      inh_q     <= inh_d;
      tmr_q     <= tmr_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      resp_q    <= resp_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE) && clk_sync;
  assign rx_enable   = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE) || accept;
  assign kbd_clk_oe  = clk_oe_q;
  assign kbd_data_oe = data_oe_q;
  assign err_code    = code;
  assign resp_data   = resp_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl at a 1 MHz system clock with a behavioural PS/2 device.
// Table of command scenarios plus hand sequences for timeout, reset and watchdog cases.
module tb_ps2_host_ctrl;

  localparam int INH_CYC  = 100;    // 100 us at 1 MHz
  localparam int RESP_CYC = 15000;  // 15 ms at 1 MHz
  localparam int BIT_CYC  = 2000;   // 2000 us at 1 MHz
  localparam int HALF     = 10;
  localparam int LIM      = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       kbd_clk_in, kbd_data_in;
  logic       kbd_clk_oe, kbd_data_oe;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_enable, busy, done, err;
  logic [1:0] err_code;
  logic [7:0] resp_data;

  ps2_host_ctrl #(
    .CLK_HZ(1_000_000), .INHIBIT_US(100), .RESP_MS(15), .MAX_RETRY(2), .BIT_TO_US(2000)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .kbd_clk_in(kbd_clk_in), .kbd_data_in(kbd_data_in), .kbd_clk_oe(kbd_clk_oe),
    .kbd_data_oe(kbd_data_oe), .rx_valid(rx_valid), .rx_data(rx_data), .rx_enable(rx_enable),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND with pull-ups.
  assign kbd_clk_in  = dev_clk & ~kbd_clk_oe;
  assign kbd_data_in = dev_data & ~kbd_data_oe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, frame_cnt = 0, en_rise = 0, err_cyc = 0;
  logic [1:0] last_code = 2'd0;
  logic en_prev = 1'b1, oe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt   <= err_cnt + 1;
      last_code <= err_code;
      err_cyc   <= cyc;
    end
    if (rx_enable && !en_prev) en_rise <= cyc;
    if (kbd_clk_oe && !oe_prev) frame_cnt <= frame_cnt + 1;
    en_prev <= rx_enable;
    oe_prev <= kbd_clk_oe;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int n = 0;
    while (!cmd_ready && n < LIM) begin tick(); n++; end
    chk("ready_wait", 32'(n < LIM), 1);
    cmd_valid = 1'b1;
    cmd_data  = b;
    #1;
    chk("busy_accept", 32'(busy), 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("ready_low_busy", 32'(cmd_ready), 0);
  endtask

  task automatic dev_pulses(input int npulse);
    repeat (HALF) tick();
    for (int k = 0; k < npulse; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      repeat (HALF) tick();
    end
  endtask

  task automatic wait_release(output bit ok);
    int n = 0;
    while (!kbd_clk_oe && n < LIM) begin tick(); n++; end
    while (kbd_clk_oe && n < LIM) begin tick(); n++; end
    ok = (n < LIM);
  endtask

  task automatic dev_frame(input bit ack_en, output logic [9:0] got, output int inh,
                           output int gap, output bit ok);
    int n = 0;
    got = '0; inh = 0; gap = 0;
    while (!kbd_clk_oe && n < LIM) begin tick(); n++; end
    ok = (n < LIM);
    while (!kbd_data_oe && inh < LIM) begin tick(); inh++; end
    chk("rx_en_gated", 32'(rx_enable), 0);
    while (kbd_clk_oe && gap < LIM) begin tick(); gap++; end
    repeat (HALF) tick();
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) tick();
      if (k <= 10) got[k-1] = kbd_data_in;
      dev_clk = 1'b1;
      if (k == 10 && ack_en) dev_data = 1'b0;
      repeat (HALF) tick();
    end
    dev_data = 1'b1;
  endtask

  task automatic give_resp(input logic [7:0] b);
    int n = 0;
    while (!rx_enable && n < LIM) begin tick(); n++; end
    chk("rx_en_wait", 32'(n < LIM), 1);
    repeat (3) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       par;
    bit         ack;
    int         nfe;
    logic [7:0] fin;
    int         frames;
    bit         exp_done;
    logic [1:0] code;
    logic [7:0] resp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0] got;
    int inh, gap, n, d0, e0, f0;
    bit ok;

    vecs[0] = '{cmd: 8'hED, par: 1'b1, ack: 1'b1, nfe: 0, fin: 8'hFA, frames: 1, exp_done: 1'b1, code: 2'd0, resp: 8'hFA};
    vecs[1] = '{cmd: 8'hFF, par: 1'b1, ack: 1'b1, nfe: 2, fin: 8'hFA, frames: 3, exp_done: 1'b1, code: 2'd0, resp: 8'hFA};
    vecs[2] = '{cmd: 8'hF4, par: 1'b0, ack: 1'b1, nfe: 3, fin: 8'h00, frames: 3, exp_done: 1'b0, code: 2'd2, resp: 8'hFE};
    vecs[3] = '{cmd: 8'h55, par: 1'b1, ack: 1'b0, nfe: 0, fin: 8'h00, frames: 1, exp_done: 1'b0, code: 2'd0, resp: 8'h00};
    vecs[4] = '{cmd: 8'h00, par: 1'b1, ack: 1'b1, nfe: 0, fin: 8'hAA, frames: 1, exp_done: 1'b0, code: 2'd2, resp: 8'hAA};

    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rx_enable", 32'(rx_enable), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_err", 32'({done, err}), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_oe", 32'({kbd_clk_oe, kbd_data_oe}), 0);
    chk("rst_resp_data", 32'(resp_data), 0);

    // A receiver byte while idle must not be taken.
    rx_valid = 1'b1;
    rx_data  = 8'hFA;
    #1;
    chk("idle_rx_done", 32'(done), 0);
    tick();
    rx_valid = 1'b0;
    chk("idle_rx_resp", 32'(resp_data), 0);

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt; e0 = err_cnt; f0 = frame_cnt;
      send_cmd(vecs[i].cmd);
      for (int f = 0; f < vecs[i].frames; f++) begin
        dev_frame(vecs[i].ack, got, inh, gap, ok);
        chk("frame_start", 32'(ok), 1);
        chk("inhibit_len", 32'(inh), 32'(INH_CYC));
        chk("start_to_release", 32'(gap), 1);
        chk("tx_data_bits", 32'(got[7:0]), 32'(vecs[i].cmd));
        chk("tx_parity", 32'(got[8]), 32'(vecs[i].par));
        chk("tx_stop_released", 32'(got[9]), 1);
        if (vecs[i].ack) give_resp((f < vecs[i].nfe) ? 8'hFE : vecs[i].fin);
      end
      repeat (5) tick();
      chk("done_count", 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      chk("err_count", 32'(err_cnt - e0), 32'(!vecs[i].exp_done));
      if (!vecs[i].exp_done) chk("err_code", 32'(last_code), 32'(vecs[i].code));
      if (vecs[i].ack) chk("resp_data", 32'(resp_data), 32'(vecs[i].resp));
      chk("inhibit_phases", 32'(frame_cnt - f0), 32'(vecs[i].frames));
      chk("idle_after_cmd", 32'({busy, kbd_clk_oe, kbd_data_oe}), 0);
    end

    // Device ACKs the frame but never answers.
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'hF2);
    dev_frame(1'b1, got, inh, gap, ok);
    chk("to_frame_start", 32'(ok), 1);
    n = 0;
    while (err_cnt == e0 && n < RESP_CYC + 200) begin tick(); n++; end
    chk("resp_timeout_err", 32'(err_cnt - e0), 1);
    chk("resp_timeout_code", 32'(last_code), 1);
    chk("resp_timeout_cycles", 32'(err_cyc - (en_rise - 1)), 32'(RESP_CYC));
    chk("resp_timeout_no_done", 32'(done_cnt - d0), 0);

    // Reset in the middle of the data bits.
    send_cmd(8'h00);
    wait_release(ok);
    chk("rst_mid_release", 32'(ok), 1);
    dev_pulses(3);
    dev_clk = 1'b0;
    repeat (HALF) tick();
    chk("pre_rst_data_oe", 32'(kbd_data_oe), 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_oe", 32'({kbd_clk_oe, kbd_data_oe}), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (5) tick();
    chk("rst_mid_ready", 32'({cmd_ready, rx_enable}), 32'h3);

`ifdef PS2_BIT_TIMEOUT_EN
    // Device clock stalls after bit 3.
    e0 = err_cnt;
    send_cmd(8'h0F);
    wait_release(ok);
    chk("bto_release", 32'(ok), 1);
    dev_pulses(4);
    n = 0;
    while (err_cnt == e0 && n < BIT_CYC + 300) begin tick(); n++; end
    chk("bit_timeout_err", 32'(err_cnt - e0), 1);
    chk("bit_timeout_code", 32'(last_code), 3);
    tick();
    chk("bit_timeout_oe", 32'({kbd_clk_oe, kbd_data_oe, busy}), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 2000000", $time);
    $fatal(1);
  end

endmodule
